disk_transfer_ctrl: RTL and testbench

Block-transfer controller for the main memory's transfer port. Moves a block of `len` words between secondary storage (disk) and main memory, word by word: loads from disk into RAM, or stores from RAM to disk. While a transfer runs it owns the RAM's transfer write path by driving `ldd`/`tr`/`addr_t`/`data_t` and reading `q_t`. It sits between the processor's I/O request logic and the disk model.

---
 rtl/disk_xfer_pkg.sv | 17 +
 rtl/disk_transfer_ctrl_if.sv | 53 +++++
 rtl/disk_transfer_ctrl.sv | 112 +++++++++++
 tb/tb_disk_transfer_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disk_xfer_pkg.sv
// Shared types and constants for the disk block-transfer controller.
package disk_xfer_pkg;

  // Controller states; LOAD_* handle disk->RAM, STORE_REQ handles RAM->disk.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_REQ  = 3'd1,
    LOAD_WR   = 3'd2,
    STORE_REQ = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Transfer direction as sampled from dir with start.
  localparam logic DIR_LOAD  = 1'b0;
  localparam logic DIR_STORE = 1'b1;

endpackage

// File: rtl/disk_transfer_ctrl_if.sv
// Request, RAM transfer-port and disk-port signals of the transfer controller.
// slave: the controller itself; master: the processor/RAM/disk side.
interface disk_transfer_ctrl_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int DISK_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH       = 8
);

  // request side
  logic                       start;
  logic                       dir;
  logic [ADDR_WIDTH-1:0]      ram_base;
  logic [DISK_ADDR_WIDTH-1:0] disk_base;
  logic [LEN_WIDTH-1:0]       len;
  logic                       busy;
  logic                       done;
  logic [LEN_WIDTH-1:0]       count;

  // RAM transfer port
  logic                       ldd;
  logic                       tr;
  logic [ADDR_WIDTH-1:0]      addr_t;
  logic [DATA_WIDTH-1:0]      data_t;
  logic [DATA_WIDTH-1:0]      q_t;

  // disk port
  logic                       disk_req;
  logic                       disk_we;
  logic [DISK_ADDR_WIDTH-1:0] disk_addr;
  logic [DATA_WIDTH-1:0]      disk_wdata;
  logic                       disk_ack;
  logic [DATA_WIDTH-1:0]      disk_rdata;

  modport slave (
    input  start, dir, ram_base, disk_base, len,
    output busy, done, count,
    output ldd, tr, addr_t, data_t,
    input  q_t,
    output disk_req, disk_we, disk_addr, disk_wdata,
    input  disk_ack, disk_rdata
  );

  modport master (
    output start, dir, ram_base, disk_base, len,
    input  busy, done, count,
    input  ldd, tr, addr_t, data_t,
    output q_t,
    input  disk_req, disk_we, disk_addr, disk_wdata,
    output disk_ack, disk_rdata
  );

endinterface

// File: rtl/disk_transfer_ctrl.sv
// Block-transfer controller: moves len words between disk and main memory,
// one word at a time, owning the RAM transfer port while busy.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; pointers/count hold last transfer
// LOAD_REQ  | disk read outstanding at disk_ptr; word captured on ack
// LOAD_WR   | captured word written to RAM at ram_ptr (tr=1)
// STORE_REQ | disk write of RAM[ram_ptr] to disk_ptr; advances on ack
// DONE      | one-cycle completion pulse, then IDLE
module disk_transfer_ctrl
  import disk_xfer_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int ADDR_WIDTH      = 16,
  parameter int DISK_ADDR_WIDTH = 16,
  parameter int LEN_WIDTH       = 8
) (
  input  logic           clk,
  input  logic           rst,
  disk_transfer_ctrl_if.slave bus
);

  state_t                     r_state;
  logic [ADDR_WIDTH-1:0]      r_ram_ptr;
  logic [DISK_ADDR_WIDTH-1:0] r_disk_ptr;
  logic [LEN_WIDTH-1:0]       r_remaining;
  logic [LEN_WIDTH-1:0]       r_count;
  logic [DATA_WIDTH-1:0]      r_data_t;

  logic                       w_busy;
  logic                       w_last;

  // The word just completed is the last one when one word was outstanding.
  assign w_last = (r_remaining == LEN_WIDTH'(1));

  // FSM plus pointer, length and count bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ram_ptr   <= '0;
      r_disk_ptr  <= '0;
      r_remaining <= '0;
      r_count     <= '0;
      r_data_t    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_ram_ptr   <= bus.ram_base;
            r_disk_ptr  <= bus.disk_base;
            r_remaining <= bus.len;
            r_count     <= '0;
            if (bus.len == '0)
              r_state <= DONE;
            else if (bus.dir == DIR_STORE)
              r_state <= STORE_REQ;
            else
              r_state <= LOAD_REQ;
          end
        end
        LOAD_REQ: begin
          if (bus.disk_ack) begin
            r_data_t <= bus.disk_rdata;
            r_state  <= LOAD_WR;
          end
        end
        LOAD_WR: begin
          r_ram_ptr   <= r_ram_ptr + ADDR_WIDTH'(1);
          r_disk_ptr  <= r_disk_ptr + DISK_ADDR_WIDTH'(1);
          r_count     <= r_count + LEN_WIDTH'(1);
          r_remaining <= r_remaining - LEN_WIDTH'(1);
          r_state     <= w_last ? DONE : LOAD_REQ;
        end
        STORE_REQ: begin
          if (bus.disk_ack) begin
            r_ram_ptr   <= r_ram_ptr + ADDR_WIDTH'(1);
            r_disk_ptr  <= r_disk_ptr + DISK_ADDR_WIDTH'(1);
            r_count     <= r_count + LEN_WIDTH'(1);
            r_remaining <= r_remaining - LEN_WIDTH'(1);
            r_state     <= w_last ? DONE : STORE_REQ;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Strobes decoded from the registered state; disk write data is taken
  // straight from the RAM read port so a store needs no capture cycle.
  always_comb begin
    w_busy         = (r_state == LOAD_REQ) || (r_state == LOAD_WR) ||
                     (r_state == STORE_REQ);
    bus.busy       = w_busy;
    bus.ldd        = w_busy;
    bus.done       = (r_state == DONE);
    bus.tr         = (r_state == LOAD_WR);
    bus.disk_req   = (r_state == LOAD_REQ) || (r_state == STORE_REQ);
    bus.disk_we    = (r_state == STORE_REQ);
    bus.disk_wdata = (r_state == STORE_REQ) ? bus.q_t : '0;
    bus.count      = r_count;
    bus.addr_t     = r_ram_ptr;
    bus.data_t     = r_data_t;
    bus.disk_addr  = r_disk_ptr;
  end

endmodule

// File: tb/tb_disk_transfer_ctrl.sv
// Self-checking bench for disk_transfer_ctrl with behavioural RAM and disk.
module tb_disk_transfer_ctrl;
  import disk_xfer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  disk_transfer_ctrl_if bus ();
  disk_transfer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [15:0] ram_mem  [0:65535];
  logic [15:0] disk_mem [0:65535];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tr_cnt = 0;
  int done_cnt = 0;
  int req_cyc = 0;
  int ldd_bad = 0;
  int ack_delay = 0;
  int wait_cnt = 0;

  logic        pl_en = 1'b0;
  logic        pl_sel = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [15:0] pl_data = '0;

  // RAM read port and disk responder (ack after ack_delay wait cycles)
  assign bus.q_t        = ram_mem[bus.addr_t];
  assign bus.disk_ack   = bus.disk_req && (wait_cnt == ack_delay);
  assign bus.disk_rdata = disk_mem[bus.disk_addr];

  // Memory updates: bench preloads, RAM transfer writes, disk writes
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) begin
      if (pl_sel) disk_mem[pl_addr] <= pl_data;
      else        ram_mem[pl_addr]  <= pl_data;
    end
    if (bus.tr) ram_mem[bus.addr_t] <= bus.data_t;
    if (bus.disk_req && bus.disk_we && bus.disk_ack)
      disk_mem[bus.disk_addr] <= bus.disk_wdata;
    if (bus.disk_req && !bus.disk_ack) wait_cnt <= wait_cnt + 1;
    else                               wait_cnt <= 0;
  end

  // Event counters sampled mid-cycle
  always @(negedge clk) begin
    if (bus.tr === 1'b1)       tr_cnt++;
    if (bus.done === 1'b1)     done_cnt++;
    if (bus.disk_req === 1'b1) req_cyc++;
    if (bus.ldd !== bus.busy)  ldd_bad++;
  end

  task automatic preload(input logic sel, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_sel = sel; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic kick(input logic d, input logic [15:0] rb, input logic [15:0] db,
                      input logic [7:0] n, output int t0);
    @(negedge clk);
    bus.start = 1'b1; bus.dir = d; bus.ram_base = rb; bus.disk_base = db; bus.len = n;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.done === 1'b1) begin
        t = cyc; ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [77:0] snap;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    snap = {bus.busy, bus.done, bus.ldd, bus.tr, bus.disk_req, bus.disk_we, bus.count,
            bus.addr_t, bus.data_t, bus.disk_addr, bus.disk_wdata};
    checks++;
    if (snap !== '0) begin
      errors++; $display("FAIL reset_outputs: got %0h expected 0", snap);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%0b done=%0b expected 0/0", bus.busy, bus.done);
    end
  endtask

  task automatic test_load_basic();
    int t0, t1, tr0;
    bit ok;
    ack_delay = 0;
    for (int i = 0; i < 4; i++) preload(1'b1, 16'(16'h0200 + i), 16'(16'hA000 + i));
    preload(1'b0, 16'h0014, 16'h5A5A);
    tr0 = tr_cnt;
    kick(DIR_LOAD, 16'h0010, 16'h0200, 8'd4, t0);
    wait_done(t1, ok);
    checks++;
    if (!ok || (t1 - t0) != 9) begin
      errors++; $display("FAIL load_done_latency: got %0d expected 9 (ok=%0b)", t1 - t0, ok);
    end
    checks++;
    if (bus.count !== 8'd4) begin
      errors++; $display("FAIL load_count: got %0d expected 4", bus.count);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL load_done_pulse: done=%0b busy=%0b expected 0/0", bus.done, bus.busy);
    end
    checks++;
    if (tr_cnt - tr0 != 4) begin
      errors++; $display("FAIL load_tr_pulses: got %0d expected 4", tr_cnt - tr0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram_mem[16'h0010 + i] !== 16'(16'hA000 + i)) begin
        errors++; $display("FAIL load_word%0d: got %0h expected %0h", i, ram_mem[16'h0010 + i], 16'hA000 + i);
      end
    end
    checks++;
    if (ram_mem[16'h0014] !== 16'h5A5A) begin
      errors++; $display("FAIL load_overrun: got %0h expected 5a5a", ram_mem[16'h0014]);
    end
  endtask

  task automatic test_store_wait();
    int t0, t1, tr0, lb0;
    bit ok;
    logic [15:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    ack_delay = 2;
    for (int i = 0; i < 3; i++) preload(1'b0, 16'(16'h0020 + i), vals[i]);
    for (int i = 0; i < 4; i++) preload(1'b1, 16'(i), 16'hDEAD);
    tr0 = tr_cnt; lb0 = ldd_bad;
    kick(DIR_STORE, 16'h0020, 16'h0000, 8'd3, t0);
    checks++;
    if (bus.ldd !== 1'b1 || bus.disk_we !== 1'b1) begin
      errors++; $display("FAIL store_ldd_we: ldd=%0b we=%0b expected 1/1", bus.ldd, bus.disk_we);
    end
    wait_done(t1, ok);
    checks++;
    if (!ok || (t1 - t0) != 10) begin
      errors++; $display("FAIL store_done_latency: got %0d expected 10 (ok=%0b)", t1 - t0, ok);
    end
    checks++;
    if (bus.count !== 8'd3) begin
      errors++; $display("FAIL store_count: got %0d expected 3", bus.count);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (disk_mem[i] !== vals[i]) begin
        errors++; $display("FAIL store_word%0d: got %0h expected %0h", i, disk_mem[i], vals[i]);
      end
    end
    checks++;
    if (disk_mem[3] !== 16'hDEAD) begin
      errors++; $display("FAIL store_overrun: got %0h expected dead", disk_mem[3]);
    end
    checks++;
    if (tr_cnt != tr0) begin
      errors++; $display("FAIL store_tr: got %0d pulses expected 0", tr_cnt - tr0);
    end
    checks++;
    if (ldd_bad != lb0) begin
      errors++; $display("FAIL store_ldd_busy: got %0d mismatching cycles expected 0", ldd_bad - lb0);
    end
    ack_delay = 0;
  endtask

  task automatic test_len_zero();
    int t0, t1, tr0, rq0;
    bit ok;
    tr0 = tr_cnt; rq0 = req_cyc;
    kick(DIR_LOAD, 16'h0100, 16'h0100, 8'd0, t0);
    wait_done(t1, ok);
    checks++;
    if (!ok || (t1 - t0) != 1) begin
      errors++; $display("FAIL len0_latency: got %0d expected 1 (ok=%0b)", t1 - t0, ok);
    end
    checks++;
    if (bus.count !== 8'd0) begin
      errors++; $display("FAIL len0_count: got %0d expected 0", bus.count);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (tr_cnt != tr0 || req_cyc != rq0) begin
      errors++; $display("FAIL len0_activity: tr=%0d req=%0d expected 0/0", tr_cnt - tr0, req_cyc - rq0);
    end
  endtask

  task automatic test_wrap();
    int t0, t1;
    bit ok;
    preload(1'b1, 16'h0700, 16'hBEE0);
    preload(1'b1, 16'h0701, 16'hBEE1);
    kick(DIR_LOAD, 16'hFFFF, 16'h0700, 8'd2, t0);
    wait_done(t1, ok);
    @(negedge clk);
    checks++;
    if (!ok || ram_mem[16'hFFFF] !== 16'hBEE0) begin
      errors++; $display("FAIL wrap_ffff: got %0h expected bee0", ram_mem[16'hFFFF]);
    end
    checks++;
    if (ram_mem[16'h0000] !== 16'hBEE1) begin
      errors++; $display("FAIL wrap_0000: got %0h expected bee1", ram_mem[16'h0000]);
    end
  endtask

  task automatic test_ignore_start();
    int t0, t1, dn0;
    bit ok;
    for (int i = 0; i < 6; i++) preload(1'b1, 16'(16'h0800 + i), 16'(16'hC000 + 3 * i));
    preload(1'b0, 16'h0400, 16'h7777);
    dn0 = done_cnt;
    kick(DIR_LOAD, 16'h0300, 16'h0800, 8'd6, t0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.dir = DIR_LOAD; bus.ram_base = 16'h0400; bus.disk_base = 16'h0900; bus.len = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(t1, ok);
    checks++;
    if (!ok || (t1 - t0) != 13) begin
      errors++; $display("FAIL ignore_latency: got %0d expected 13 (ok=%0b)", t1 - t0, ok);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt - dn0 != 1) begin
      errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - dn0);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (ram_mem[16'h0300 + i] !== 16'(16'hC000 + 3 * i)) begin
        errors++; $display("FAIL ignore_word%0d: got %0h expected %0h", i, ram_mem[16'h0300 + i], 16'hC000 + 3 * i);
      end
    end
    checks++;
    if (ram_mem[16'h0400] !== 16'h7777) begin
      errors++; $display("FAIL ignore_second: got %0h expected 7777", ram_mem[16'h0400]);
    end
  endtask

  task automatic test_reset_mid();
    int t0, t1, n, tr0;
    bit ok;
    logic [69:0] snap;
    for (int i = 0; i < 5; i++) begin
      preload(1'b1, 16'(16'h0600 + i), 16'(16'hD100 + i));
      preload(1'b0, 16'(16'h0500 + i), 16'h0BAD);
    end
    kick(DIR_LOAD, 16'h0500, 16'h0600, 8'd5, t0);
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      if (bus.tr === 1'b1) n++;
      if (n < 2) @(negedge clk);
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL rstmid_progress: got %0d writes expected 2", n);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    snap = {bus.busy, bus.done, bus.ldd, bus.tr, bus.disk_req, bus.disk_we,
            bus.addr_t, bus.data_t, bus.disk_addr, bus.disk_wdata};
    checks++;
    if (snap !== '0) begin
      errors++; $display("FAIL rstmid_outputs: got %0h expected 0", snap);
    end
    rst = 1'b0;
    tr0 = tr_cnt;
    repeat (6) @(negedge clk);
    checks++;
    if (tr_cnt != tr0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet: tr=%0d busy=%0b expected 0/0", tr_cnt - tr0, bus.busy);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ram_mem[16'h0500 + i] !== ((i < 2) ? 16'(16'hD100 + i) : 16'h0BAD)) begin
        errors++; $display("FAIL rstmid_word%0d: got %0h", i, ram_mem[16'h0500 + i]);
      end
    end
    kick(DIR_LOAD, 16'h0500, 16'h0602, 8'd3, t0);
    wait_done(t1, ok);
    @(negedge clk);
    checks++;
    if (!ok || (t1 - t0) != 7 || ram_mem[16'h0502] !== 16'hD104) begin
      errors++; $display("FAIL rstmid_restart: latency %0d word %0h expected 7/d104", t1 - t0, ram_mem[16'h0502]);
    end
  endtask

  task automatic test_random();
    int t0, t1, tr0, lb0, exp_lat, n, d;
    bit ok;
    logic dr;
    logic [15:0] rb, db, a, sent;
    logic [15:0] src [16];
    for (int it = 0; it < 20; it++) begin
      dr = 1'($urandom_range(0, 1));
      n  = $urandom_range(0, 10);
      d  = $urandom_range(0, 3);
      rb = 16'($urandom);
      db = 16'($urandom);
      sent = 16'($urandom);
      ack_delay = d;
      for (int i = 0; i < n; i++) begin
        src[i] = 16'($urandom);
        if (dr == DIR_LOAD) preload(1'b1, db + 16'(i), src[i]);
        else                preload(1'b0, rb + 16'(i), src[i]);
      end
      if (dr == DIR_LOAD) preload(1'b0, rb + 16'(n), sent);
      else                preload(1'b1, db + 16'(n), sent);
      tr0 = tr_cnt; lb0 = ldd_bad;
      if (n == 0)              exp_lat = 1;
      else if (dr == DIR_LOAD) exp_lat = 1 + n * (2 + d);
      else                     exp_lat = 1 + n * (1 + d);
      kick(dr, rb, db, 8'(n), t0);
      wait_done(t1, ok);
      checks++;
      if (!ok || (t1 - t0) != exp_lat) begin
        errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", it, t1 - t0, exp_lat);
      end
      checks++;
      if (bus.count !== 8'(n)) begin
        errors++; $display("FAIL rnd%0d_count: got %0d expected %0d", it, bus.count, n);
      end
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        checks++;
        if (dr == DIR_LOAD) begin
          a = rb + 16'(i);
          if (ram_mem[a] !== src[i]) begin
            errors++; $display("FAIL rnd%0d_ram%0d: got %0h expected %0h", it, i, ram_mem[a], src[i]);
          end
        end else begin
          a = db + 16'(i);
          if (disk_mem[a] !== src[i]) begin
            errors++; $display("FAIL rnd%0d_disk%0d: got %0h expected %0h", it, i, disk_mem[a], src[i]);
          end
        end
      end
      checks++;
      if (dr == DIR_LOAD) begin
        if (ram_mem[rb + 16'(n)] !== sent) begin
          errors++; $display("FAIL rnd%0d_overrun: got %0h expected %0h", it, ram_mem[rb + 16'(n)], sent);
        end
      end else begin
        if (disk_mem[db + 16'(n)] !== sent) begin
          errors++; $display("FAIL rnd%0d_overrun: got %0h expected %0h", it, disk_mem[db + 16'(n)], sent);
        end
      end
      checks++;
      if (tr_cnt - tr0 != ((dr == DIR_LOAD) ? n : 0) || ldd_bad != lb0) begin
        errors++; $display("FAIL rnd%0d_strobes: tr=%0d ldd_bad=%0d expected %0d/0", it, tr_cnt - tr0,
                           ldd_bad - lb0, (dr == DIR_LOAD) ? n : 0);
      end
    end
    ack_delay = 0;
  endtask

  initial begin
    bus.start = 1'b0; bus.dir = 1'b0; bus.ram_base = '0; bus.disk_base = '0; bus.len = '0;
    test_reset();
    test_load_basic();
    test_store_wait();
    test_len_zero();
    test_wrap();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
